// File: rtl/datard_if.sv
// Signal bundle for datard: scheduler command, SRAM read port and egress port.
// The master modport is the datard view; slave is the surrounding logic.
interface datard_if #(
  parameter int num_of_ports         = 16,
  parameter int sg_data_width        = 64,
  parameter int sg_address_width     = 12,
  parameter int sg_des_width         = 4,
  parameter int sg_pack_length_width = 7
);
  logic                            start;
  logic [sg_address_width-1:0]     address_in;
  logic [sg_pack_length_width-1:0] pack_length_in;
  logic [sg_des_width-1:0]         des_port_in;
  logic                            busy;
  logic                            read_enable;
  logic [sg_address_width-1:0]     address_read;
  logic [sg_data_width-1:0]        data_read;
  logic [sg_data_width-1:0]        data_out;
  logic                            data_valid;
  logic                            port_ready;
  logic                            sop;
  logic [num_of_ports-1:0]         eop;
  logic [sg_des_width-1:0]         des_port;
  logic                            done;

  modport master (
    input  start, address_in, pack_length_in, des_port_in, data_read, port_ready,
    output busy, read_enable, address_read, data_out, data_valid, sop, eop, des_port, done
  );

  modport slave (
    output start, address_in, pack_length_in, des_port_in, data_read, port_ready,
    input  busy, read_enable, address_read, data_out, data_valid, sop, eop, des_port, done
  );
endinterface

// File: rtl/datard.sv
// Packet read engine: issues SRAM reads for one packet and streams the words
// through a 2-entry skid buffer to the egress port with sop/eop framing.
module datard #(
  parameter int num_of_ports         = 16,
  parameter int sg_data_width        = 64,
  parameter int sg_address_width     = 12,
  parameter int sg_des_width         = 4,
  parameter int sg_pack_length_width = 7
) (
  input logic       clk,
  input logic       rst,
  datard_if.master  bus
);
  localparam int AW = sg_address_width;
  localparam int LW = sg_pack_length_width;
  localparam int DW = sg_des_width;
  localparam int WW = sg_data_width;
  localparam int NP = num_of_ports;

  localparam logic [LW-1:0] LEN_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LEN_ONE  = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [NP-1:0] PORT_ONE = {{(NP-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [AW-1:0]   addr_r;
  logic [LW-1:0]   len_r;
  logic [LW-1:0]   issued_r;
  logic [LW-1:0]   delivered_r;
  logic [DW-1:0]   des_r;
  logic            inflight_r;
  logic            done_r;
  logic [1:0]      occ_r;
  logic            wr_ptr_r;
  logic            rd_ptr_r;
  logic [WW-1:0]   buf0_r;
  logic [WW-1:0]   buf1_r;

  logic            accept_s;
  logic            data_valid_s;
  logic            pop_s;
  logic [2:0]      load_s;
  logic            issue_s;
  logic            last_issue_s;
  logic            last_pop_s;
  logic [LW-1:0]   len_m1_s;
  logic [NP-1:0]   eop_s;

  // Per-cycle handshake, issue and framing decisions.
  always_comb begin
    accept_s     = (state_r == IDLE) && bus.start && (bus.pack_length_in != LEN_ZERO);
    len_m1_s     = len_r - LEN_ONE;
    data_valid_s = (occ_r != 2'd0);
    pop_s        = data_valid_s && bus.port_ready;
    // Occupancy the buffer will hold once the in-flight word lands, net of this cycle's pop.
    load_s       = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    issue_s      = (state_r == READ) && (issued_r < len_r) && (load_s < 3'd2);
    last_issue_s = issue_s && (issued_r == len_m1_s);
    last_pop_s   = pop_s && (delivered_r == len_m1_s);
    if (data_valid_s && (delivered_r == len_m1_s)) begin
      eop_s = PORT_ONE << des_r;
    end else begin
      eop_s = {NP{1'b0}};
    end
  end

  // Next-state logic for the packet sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = READ;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (last_issue_s) begin
          state_s = DRAIN;
        end else begin
          state_s = READ;
        end
      end
      DRAIN: begin
        if (last_pop_s) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Command latch, address/issue/deliver counters and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r      <= {AW{1'b0}};
      len_r       <= LEN_ZERO;
      des_r       <= {DW{1'b0}};
      issued_r    <= LEN_ZERO;
      delivered_r <= LEN_ZERO;
      inflight_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      done_r     <= (state_r == DRAIN) && last_pop_s;
      if (accept_s) begin
        addr_r      <= bus.address_in;
        len_r       <= bus.pack_length_in;
        des_r       <= bus.des_port_in;
        issued_r    <= LEN_ZERO;
        delivered_r <= LEN_ZERO;
      end else begin
        if (issue_s) begin
          addr_r   <= addr_r + ADDR_ONE;
          issued_r <= issued_r + LEN_ONE;
        end
        if (pop_s) begin
          delivered_r <= delivered_r + LEN_ONE;
        end
      end
    end
  end

  // Two-entry skid buffer; a returning word and a pop may share a cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf0_r   <= {WW{1'b0}};
      buf1_r   <= {WW{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else begin
      if (inflight_r) begin
        if (wr_ptr_r) begin
          buf1_r <= bus.data_read;
        end else begin
          buf0_r <= bus.data_read;
        end
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      occ_r <= occ_r + {1'b0, inflight_r} - {1'b0, pop_s};
    end
  end

  assign bus.busy         = (state_r != IDLE);
  assign bus.read_enable  = issue_s;
  assign bus.address_read = issue_s ? addr_r : {AW{1'b0}};
  assign bus.data_out     = rd_ptr_r ? buf1_r : buf0_r;
  assign bus.data_valid   = data_valid_s;
  assign bus.sop          = data_valid_s && (delivered_r == LEN_ZERO);
  assign bus.eop          = eop_s;
  assign bus.des_port     = des_r;
  assign bus.done         = done_r;
endmodule

// File: tb/tb_datard.sv
// Directed bench for datard: cycle-by-cycle expectations for each scenario,
// with a one-cycle-latency SRAM stand-in whose word encodes its address.
module tb_datard;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  datard_if bus ();
  datard dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [63:0] word(input logic [11:0] a);
    return {52'hC0DE_0000_0000_0, a};
  endfunction

  // {busy, read_enable, address (only while reading), data_valid, sop, eop, done}
  function automatic logic [32:0] ctl();
    return {bus.busy, bus.read_enable, (bus.read_enable ? bus.address_read : 12'h000),
            bus.data_valid, bus.sop, bus.eop, bus.done};
  endfunction

  function automatic logic [100:0] outs();
    return {bus.busy, bus.read_enable, bus.address_read, bus.data_out, bus.data_valid,
            bus.sop, bus.eop, bus.des_port, bus.done};
  endfunction

  // Called at the negedge: latch the read request, move to the next cycle, answer it.
  task automatic adv();
    logic r;
    logic [11:0] a;
    r = bus.read_enable;
    a = bus.address_read;
    @(posedge clk);
    #1;
    bus.data_read = r ? word(a) : 64'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.start = 1'($urandom);
      bus.address_in = 12'($urandom);
      bus.pack_length_in = 7'($urandom);
      bus.des_port_in = 4'($urandom);
      bus.data_read = {$urandom, $urandom};
      bus.port_ready = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (outs() !== 101'h0) begin
        n_bad++;
        $display("FAIL reset_outs c%0d got %h want 0", c, outs());
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.port_ready = 1'b1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.busy, bus.read_enable} !== 2'b00) begin
        n_bad++;
        $display("FAIL reset_idle c%0d got %b want 00", c, {bus.busy, bus.read_enable});
      end
      adv();
    end
  endtask

  task automatic test_basic();
    logic e_busy, e_re, e_val, e_sop, e_done;
    logic [11:0] e_addr, e_a;
    logic [15:0] e_eop;
    logic [32:0] exp_ctl;
    bus.address_in = 12'h010; bus.pack_length_in = 7'd4; bus.des_port_in = 4'd3;
    bus.port_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      bus.start = (c == 0);
      e_re = (c >= 1 && c <= 4);
      e_addr = e_re ? 12'h010 + 12'(c - 1) : 12'h000;
      e_val = (c >= 3 && c <= 6);
      e_a = 12'h010 + 12'(c - 3);
      e_sop = (c == 3);
      e_eop = (c == 6) ? 16'h0008 : 16'h0000;
      e_done = (c == 7);
      e_busy = (c >= 1 && c <= 6);
      exp_ctl = {e_busy, e_re, e_addr, e_val, e_sop, e_eop, e_done};
      @(negedge clk);
      n_cmp++;
      if (ctl() !== exp_ctl) begin
        n_bad++;
        $display("FAIL basic_ctl c%0d got %h want %h", c, ctl(), exp_ctl);
      end
      if (e_val) begin
        n_cmp++;
        if ({bus.des_port, bus.data_out} !== {4'd3, word(e_a)}) begin
          n_bad++;
          $display("FAIL basic_data c%0d got %h want %h", c, {bus.des_port, bus.data_out}, {4'd3, word(e_a)});
        end
      end
      adv();
    end
  endtask

  task automatic test_backpressure();
    logic e_busy, e_re, e_val, e_sop, e_done;
    logic [11:0] e_addr, e_a;
    logic [15:0] e_eop;
    logic [32:0] exp_ctl;
    bus.address_in = 12'h100; bus.pack_length_in = 7'd3; bus.des_port_in = 4'd5;
    for (int c = 0; c < 12; c++) begin
      bus.start = (c == 0);
      bus.port_ready = !(c >= 3 && c <= 6);
      e_re = (c == 1 || c == 2 || c == 7);
      e_addr = (c == 1) ? 12'h100 : (c == 2) ? 12'h101 : (c == 7) ? 12'h102 : 12'h000;
      e_val = (c >= 3 && c <= 9);
      e_a = (c <= 7) ? 12'h100 : (c == 8) ? 12'h101 : 12'h102;
      e_sop = (c >= 3 && c <= 7);
      e_eop = (c == 9) ? 16'h0020 : 16'h0000;
      e_done = (c == 10);
      e_busy = (c >= 1 && c <= 9);
      exp_ctl = {e_busy, e_re, e_addr, e_val, e_sop, e_eop, e_done};
      @(negedge clk);
      n_cmp++;
      if (ctl() !== exp_ctl) begin
        n_bad++;
        $display("FAIL bp_ctl c%0d got %h want %h", c, ctl(), exp_ctl);
      end
      if (e_val) begin
        n_cmp++;
        if ({bus.des_port, bus.data_out} !== {4'd5, word(e_a)}) begin
          n_bad++;
          $display("FAIL bp_data c%0d got %h want %h", c, {bus.des_port, bus.data_out}, {4'd5, word(e_a)});
        end
      end
      adv();
    end
    bus.port_ready = 1'b1;
  endtask

  task automatic test_wrap();
    logic e_busy, e_re, e_val, e_sop, e_done;
    logic [11:0] e_addr, e_a;
    logic [15:0] e_eop;
    logic [32:0] exp_ctl;
    bus.address_in = 12'hFFE; bus.pack_length_in = 7'd3; bus.des_port_in = 4'd0;
    for (int c = 0; c < 8; c++) begin
      bus.start = (c == 0);
      e_re = (c >= 1 && c <= 3);
      e_addr = e_re ? 12'hFFE + 12'(c - 1) : 12'h000;
      e_val = (c >= 3 && c <= 5);
      e_a = 12'hFFE + 12'(c - 3);
      e_sop = (c == 3);
      e_eop = (c == 5) ? 16'h0001 : 16'h0000;
      e_done = (c == 6);
      e_busy = (c >= 1 && c <= 5);
      exp_ctl = {e_busy, e_re, e_addr, e_val, e_sop, e_eop, e_done};
      @(negedge clk);
      n_cmp++;
      if (ctl() !== exp_ctl) begin
        n_bad++;
        $display("FAIL wrap_ctl c%0d got %h want %h", c, ctl(), exp_ctl);
      end
      if (e_val) begin
        n_cmp++;
        if (bus.data_out !== word(e_a)) begin
          n_bad++;
          $display("FAIL wrap_data c%0d got %h want %h", c, bus.data_out, word(e_a));
        end
      end
      adv();
    end
  endtask

  task automatic test_single();
    logic [32:0] exp_ctl;
    bus.address_in = 12'h02A; bus.pack_length_in = 7'd1; bus.des_port_in = 4'd15;
    for (int c = 0; c < 6; c++) begin
      bus.start = (c == 0);
      exp_ctl = {(c >= 1 && c <= 3), (c == 1), (c == 1) ? 12'h02A : 12'h000,
                 (c == 3), (c == 3), (c == 3) ? 16'h8000 : 16'h0000, (c == 4)};
      @(negedge clk);
      n_cmp++;
      if (ctl() !== exp_ctl) begin
        n_bad++;
        $display("FAIL single_ctl c%0d got %h want %h", c, ctl(), exp_ctl);
      end
      if (c == 3) begin
        n_cmp++;
        if ({bus.des_port, bus.data_out} !== {4'd15, word(12'h02A)}) begin
          n_bad++;
          $display("FAIL single_data got %h want %h", {bus.des_port, bus.data_out}, {4'd15, word(12'h02A)});
        end
      end
      adv();
    end
  endtask

  task automatic test_ignored();
    logic e_busy, e_re, e_val, e_sop, e_done;
    logic [11:0] e_addr, e_a;
    logic [15:0] e_eop;
    logic [32:0] exp_ctl;
    for (int c = 0; c < 9; c++) begin
      bus.start = (c == 0 || c == 2);
      bus.address_in = (c == 2) ? 12'h300 : 12'h040;
      bus.pack_length_in = (c == 2) ? 7'd1 : 7'd4;
      bus.des_port_in = (c == 2) ? 4'd9 : 4'd2;
      e_re = (c >= 1 && c <= 4);
      e_addr = e_re ? 12'h040 + 12'(c - 1) : 12'h000;
      e_val = (c >= 3 && c <= 6);
      e_a = 12'h040 + 12'(c - 3);
      e_sop = (c == 3);
      e_eop = (c == 6) ? 16'h0004 : 16'h0000;
      e_done = (c == 7);
      e_busy = (c >= 1 && c <= 6);
      exp_ctl = {e_busy, e_re, e_addr, e_val, e_sop, e_eop, e_done};
      @(negedge clk);
      n_cmp++;
      if (ctl() !== exp_ctl) begin
        n_bad++;
        $display("FAIL busy_start_ctl c%0d got %h want %h", c, ctl(), exp_ctl);
      end
      if (e_val) begin
        n_cmp++;
        if ({bus.des_port, bus.data_out} !== {4'd2, word(e_a)}) begin
          n_bad++;
          $display("FAIL busy_start_data c%0d got %h want %h", c, {bus.des_port, bus.data_out}, {4'd2, word(e_a)});
        end
      end
      adv();
    end
    bus.address_in = 12'h555; bus.pack_length_in = 7'd0; bus.des_port_in = 4'd1;
    for (int c = 0; c < 6; c++) begin
      bus.start = (c == 0);
      @(negedge clk);
      n_cmp++;
      if (ctl() !== 33'h0) begin
        n_bad++;
        $display("FAIL len0_ctl c%0d got %h want 0", c, ctl());
      end
      adv();
    end
  endtask

  task automatic test_back_to_back();
    logic e_busy, e_re, e_val, e_sop, e_done;
    logic [11:0] e_addr, e_a;
    logic [15:0] e_eop;
    logic [3:0]  e_des;
    logic [32:0] exp_ctl;
    for (int c = 0; c < 11; c++) begin
      bus.start = (c == 0 || c == 5);
      bus.address_in = (c == 5) ? 12'h210 : 12'h200;
      bus.pack_length_in = (c == 5) ? 7'd1 : 7'd2;
      bus.des_port_in = (c == 5) ? 4'd6 : 4'd4;
      e_re = (c == 1 || c == 2 || c == 6);
      e_addr = (c == 6) ? 12'h210 : e_re ? 12'h200 + 12'(c - 1) : 12'h000;
      e_val = (c == 3 || c == 4 || c == 8);
      e_a = (c == 8) ? 12'h210 : 12'h200 + 12'(c - 3);
      e_des = (c == 8) ? 4'd6 : 4'd4;
      e_sop = (c == 3 || c == 8);
      e_eop = (c == 4) ? 16'h0010 : (c == 8) ? 16'h0040 : 16'h0000;
      e_done = (c == 5 || c == 9);
      e_busy = (c >= 1 && c <= 4) || (c >= 6 && c <= 8);
      exp_ctl = {e_busy, e_re, e_addr, e_val, e_sop, e_eop, e_done};
      @(negedge clk);
      n_cmp++;
      if (ctl() !== exp_ctl) begin
        n_bad++;
        $display("FAIL b2b_ctl c%0d got %h want %h", c, ctl(), exp_ctl);
      end
      if (e_val) begin
        n_cmp++;
        if ({bus.des_port, bus.data_out} !== {e_des, word(e_a)}) begin
          n_bad++;
          $display("FAIL b2b_data c%0d got %h want %h", c, {bus.des_port, bus.data_out}, {e_des, word(e_a)});
        end
      end
      adv();
    end
  endtask

  task automatic test_async_reset();
    logic [32:0] exp_ctl;
    bus.address_in = 12'h080; bus.pack_length_in = 7'd8; bus.des_port_in = 4'd1;
    bus.port_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.start = (c == 0);
      exp_ctl = {(c >= 1), (c >= 1), (c >= 1) ? 12'h080 + 12'(c - 1) : 12'h000,
                 (c >= 3), (c == 3), 16'h0000, 1'b0};
      @(negedge clk);
      n_cmp++;
      if (ctl() !== exp_ctl) begin
        n_bad++;
        $display("FAIL arst_pre_ctl c%0d got %h want %h", c, ctl(), exp_ctl);
      end
      adv();
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== 101'h0) begin
      n_bad++;
      $display("FAIL arst_immediate got %h want 0", outs());
    end
    @(negedge clk);
    n_cmp++;
    if (outs() !== 101'h0) begin
      n_bad++;
      $display("FAIL arst_held got %h want 0", outs());
    end
    adv();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (ctl() !== 33'h0) begin
        n_bad++;
        $display("FAIL arst_after c%0d got %h want 0", c, ctl());
      end
      adv();
    end
    bus.address_in = 12'h0C0; bus.pack_length_in = 7'd2; bus.des_port_in = 4'd7;
    for (int c = 0; c < 7; c++) begin
      bus.start = (c == 0);
      exp_ctl = {(c >= 1 && c <= 4), (c == 1 || c == 2),
                 (c == 1 || c == 2) ? 12'h0C0 + 12'(c - 1) : 12'h000,
                 (c == 3 || c == 4), (c == 3), (c == 4) ? 16'h0080 : 16'h0000, (c == 5)};
      @(negedge clk);
      n_cmp++;
      if (ctl() !== exp_ctl) begin
        n_bad++;
        $display("FAIL arst_fresh_ctl c%0d got %h want %h", c, ctl(), exp_ctl);
      end
      if (c == 3 || c == 4) begin
        n_cmp++;
        if ({bus.des_port, bus.data_out} !== {4'd7, word(12'h0C0 + 12'(c - 3))}) begin
          n_bad++;
          $display("FAIL arst_fresh_data c%0d got %h want %h", c, {bus.des_port, bus.data_out},
                   {4'd7, word(12'h0C0 + 12'(c - 3))});
        end
      end
      adv();
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    bus.address_in = 12'h000;
    bus.pack_length_in = 7'd0;
    bus.des_port_in = 4'd0;
    bus.data_read = 64'h0;
    bus.port_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_single();
    test_ignored();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
